adder_rr_scheduler: RTL and testbench
=====================================

Name: adder_rr_scheduler

Overview:
Shares one 8-bit adder (9-bit sum) between NUM_REQ requesters using a round-robin grant.
Accepts one operand pair per transaction, computes the registered sum, and presents it with the requester ID on a valid/ready output port.
Also keeps a saturating count of completed operations for the bench scoreboard.
Sits between operand sources (stimulus or upstream engines) and the result consumer.

Parameters:
NUM_REQ, 4, number of requesters (2..8)
WIDTH, 8, operand width; sum is WIDTH+1 bits
ID_W, 2, requester ID width, must equal ceil(log2(NUM_REQ))
CNT_W, 16, width of completed-operation counter

Ports:
clk  in  1  rising-edge clock
rst  in  1  synchronous active-high reset
req  in  NUM_REQ  per-requester request; a requester holds it with stable operands until granted
a_in  in  NUM_REQ*WIDTH  packed operand A; requester k uses bits [k*WIDTH +: WIDTH]
b_in  in  NUM_REQ*WIDTH  packed operand B, same packing
gnt  out  NUM_REQ  one-hot, one-cycle pulse; operands of the granted requester are captured that cycle
y  out  WIDTH+1  registered sum
y_id  out  ID_W  index of the requester that owns y
y_valid  out  1  result valid
y_ready  in  1  consumer accepts the result when y_valid && y_ready
busy  out  1  high in any state except IDLE
op_count  out  CNT_W  number of completed result handshakes; saturates at all-ones

Behaviour:
- Reset (rst=1 at a clk edge) overrides everything, including mid-transaction:
  - state=IDLE; gnt=0, y=0, y_id=0, y_valid=0, busy=0, op_count=0; rr pointer=0.
  - Any in-flight result is discarded.
- FSM states:
  - IDLE: if req!=0, select the requester and pulse gnt for exactly that requester this cycle. Latch its A and B operands into op_a/op_b and its index into id_q. Next state CALC. If req==0, stay in IDLE with gnt=0.
  - CALC: y <= op_a + op_b, zero-extended to WIDTH+1 with no overflow loss (255+255=510). y_id <= id_q; y_valid <= 1. Next state OUT.
  - OUT: hold y, y_id and y_valid stable while y_ready=0.
    - On y_valid && y_ready: y_valid <= 0, op_count increments unless saturated, next state IDLE.
    - No new grant is issued in the handshake cycle.
- Arbitration:
  - Search starts at the rr pointer and wraps modulo NUM_REQ; the first asserted req wins.
  - After a grant to k, the pointer becomes (k+1) mod NUM_REQ, so k=NUM_REQ-1 wraps to 0.
  - Requests asserted while busy are ignored until IDLE.
- gnt is combinational from state==IDLE, req and the pointer.
  - At most one bit is set.
  - It is never asserted outside IDLE.
- Latency: grant cycle = T; y_valid first high at T+2.
  - With y_ready held at 1, the handshake occurs at T+2, the next grant at T+3, and peak throughput is 1 op per 3 cycles.
- A req dropped after the grant has no effect, because operands are already latched.
- A requester granted in cycle T must deassert or change req/operands from T+1 if it has no further work; otherwise it is re-queued in round-robin order.

Test Plan:
1. Single request: rst for 2 cycles, then req=0001 with a0=8'h0F, b0=8'h01, y_ready=1 -> gnt=0001 for one cycle; two cycles later y=9'h010, y_id=0, y_valid=1 for one cycle; op_count=1.
2. Overflow/width: req=0100 with a2=8'hFF, b2=8'hFF -> y=9'h1FE, y_id=2; a2=0, b2=0 -> y=0.
3. Round-robin fairness: req=1111 held with operand pairs (i,i) for i=0..3 -> grants in order 0,1,2,3,0 with results 0,2,4,6,0; no requester is granted twice before the others are served.
4. Backpressure: result pending with y_ready=0 for 5 cycles while req=0010 -> y and y_id stable, y_valid stays 1, gnt stays 0. Raising y_ready completes the handshake, and gnt=0010 appears the following cycle.
5. Reset mid-operation: assert rst in the CALC state and then in OUT -> the next cycle has y_valid=0, busy=0, op_count=0, and the pointer is back at 0. With req=1010, the first grant goes to requester 1.
6. Vector sweep: 25 vectors a=i, b=i (i=0..24) through requester 3, with the scoreboard comparing y against 2*i -> 0 mismatches and op_count=25; print TEST PASSED/TEST FAILED.

Source files
------------

// File: rtl/adder_rr_scheduler_if.sv
// Bus bundle for the shared-adder scheduler: request/operand inputs,
// one-hot grant, and the valid/ready result port with status.
interface adder_rr_scheduler_if #(
  parameter int NUM_REQ = 4,
  parameter int WIDTH   = 8,
  parameter int ID_W    = 2,
  parameter int CNT_W   = 16
);
  logic [NUM_REQ-1:0]       req;
  logic [NUM_REQ*WIDTH-1:0] a_in;
  logic [NUM_REQ*WIDTH-1:0] b_in;
  logic [NUM_REQ-1:0]       gnt;
  logic [WIDTH:0]           y;
  logic [ID_W-1:0]          y_id;
  logic                     y_valid;
  logic                     y_ready;
  logic                     busy;
  logic [CNT_W-1:0]         op_count;

  // Requester/consumer side
  modport master (
    output req, a_in, b_in, y_ready,
    input  gnt, y, y_id, y_valid, busy, op_count
  );

  // Scheduler side
  modport slave (
    input  req, a_in, b_in, y_ready,
    output gnt, y, y_id, y_valid, busy, op_count
  );
endinterface

// File: rtl/adder_rr_scheduler.sv
// One WIDTH-bit adder shared by NUM_REQ requesters under round-robin grant.
// IDLE grants and latches operands, CALC registers the sum, OUT holds the
// result until the consumer accepts it. Counts completed handshakes.
module adder_rr_scheduler #(
  parameter int NUM_REQ = 4,
  parameter int WIDTH   = 8,
  parameter int ID_W    = 2,
  parameter int CNT_W   = 16
) (
  input logic                clk,
  input logic                rst,
  adder_rr_scheduler_if.slave bus
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] CALC = 2'd1;
  localparam logic [1:0] OUT  = 2'd2;

  logic [1:0]         state_q, state_d;
  logic [ID_W-1:0]    ptr_q, ptr_d;
  logic [ID_W-1:0]    id_q, id_d;
  logic [WIDTH-1:0]   op_a_q, op_a_d;
  logic [WIDTH-1:0]   op_b_q, op_b_d;
  logic [WIDTH:0]     y_q, y_d;
  logic [ID_W-1:0]    y_id_q, y_id_d;
  logic               y_valid_q, y_valid_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;

  logic [ID_W-1:0]    win_idx;
  logic               win_found;
  logic [ID_W:0]      cand;
  logic [NUM_REQ-1:0] gnt;

  // Round-robin search: first asserted request at or after the pointer, wrapping
  always_comb begin
    win_idx   = '0;
    win_found = 1'b0;
    cand      = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      cand = {1'b0, ptr_q} + (ID_W+1)'(i);
      if (cand >= (ID_W+1)'(NUM_REQ)) cand = cand - (ID_W+1)'(NUM_REQ);
      if (!win_found && bus.req[cand]) begin
        win_found = 1'b1;
        win_idx   = cand[ID_W-1:0];
      end
    end
  end

  // Grant pulse only while idle
  always_comb begin
    gnt = '0;
    if (state_q == IDLE && win_found) gnt[win_idx] = 1'b1;
  end

  // Next-state and datapath update for the three-phase transaction
  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    id_d      = id_q;
    op_a_d    = op_a_q;
    op_b_d    = op_b_q;
    y_d       = y_q;
    y_id_d    = y_id_q;
    y_valid_d = y_valid_q;
    cnt_d     = cnt_q;
    case (state_q)
      IDLE: begin
        if (win_found) begin
          op_a_d  = bus.a_in[win_idx*WIDTH +: WIDTH];
          op_b_d  = bus.b_in[win_idx*WIDTH +: WIDTH];
          id_d    = win_idx;
          ptr_d   = (win_idx == ID_W'(NUM_REQ-1)) ? '0 : win_idx + ID_W'(1);
          state_d = CALC;
        end
      end
      CALC: begin
        y_d       = {1'b0, op_a_q} + {1'b0, op_b_q};
        y_id_d    = id_q;
        y_valid_d = 1'b1;
        state_d   = OUT;
      end
      OUT: begin
        if (y_valid_q && bus.y_ready) begin
          y_valid_d = 1'b0;
          if (cnt_q != '1) cnt_d = cnt_q + CNT_W'(1);
          state_d   = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      ptr_q     <= '0;
      id_q      <= '0;
      op_a_q    <= '0;
      op_b_q    <= '0;
      y_q       <= '0;
      y_id_q    <= '0;
      y_valid_q <= 1'b0;
      cnt_q     <= '0;
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      id_q      <= id_d;
      op_a_q    <= op_a_d;
      op_b_q    <= op_b_d;
      y_q       <= y_d;
      y_id_q    <= y_id_d;
      y_valid_q <= y_valid_d;
      cnt_q     <= cnt_d;
    end
  end

  assign bus.gnt      = gnt;
  assign bus.y        = y_q;
  assign bus.y_id     = y_id_q;
  assign bus.y_valid  = y_valid_q;
  assign bus.busy     = (state_q != IDLE);
  assign bus.op_count = cnt_q;

endmodule

// File: tb/tb_adder_rr_scheduler.sv
// Self-checking bench for adder_rr_scheduler: scenario tasks with inline
// checks plus a grant-driven scoreboard of expected results.
module tb_adder_rr_scheduler;
  localparam int NUM_REQ = 4;
  localparam int W       = 8;
  localparam int ID_W    = 2;
  localparam int CNT_W   = 16;

  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;

  logic [W-1:0] a_arr [NUM_REQ];
  logic [W-1:0] b_arr [NUM_REQ];

  adder_rr_scheduler_if #(.NUM_REQ(NUM_REQ), .WIDTH(W), .ID_W(ID_W), .CNT_W(CNT_W)) bus ();

  adder_rr_scheduler #(.NUM_REQ(NUM_REQ), .WIDTH(W), .ID_W(ID_W), .CNT_W(CNT_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  always_comb begin
    bus.a_in = '0;
    bus.b_in = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      bus.a_in[k*W +: W] = a_arr[k];
      bus.b_in[k*W +: W] = b_arr[k];
    end
  end

  // Scoreboard: model arbitration picks the expected winner on each grant,
  // its sum is queued and compared on the result handshake.
  logic [ID_W+W:0]    exp_q [$];
  logic [ID_W+W:0]    m_exp;
  logic [NUM_REQ-1:0] m_oh;
  int                 mptr = 0;
  int                 mk;

  always @(negedge clk) begin
    if (rst) begin
      exp_q.delete();
      mptr = 0;
    end else begin
      if (bus.gnt != '0) begin
        mk = -1;
        for (int i = 0; i < NUM_REQ; i++)
          if (mk < 0 && bus.req[(mptr+i)%NUM_REQ]) mk = (mptr+i)%NUM_REQ;
        checks++;
        if (mk < 0) begin
          errors++;
          $display("FAIL sb_gnt: gnt=%b with req=%b, required no grant", bus.gnt, bus.req);
        end else begin
          m_oh = '0;
          m_oh[mk] = 1'b1;
          if (bus.gnt !== m_oh) begin
            errors++;
            $display("FAIL sb_gnt: gnt=%b, required %b", bus.gnt, m_oh);
          end
          exp_q.push_back({ID_W'(mk), {1'b0, a_arr[mk]} + {1'b0, b_arr[mk]}});
          mptr = (mk + 1) % NUM_REQ;
        end
      end
      if (bus.y_valid && bus.y_ready) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL sb_result: unexpected result id=%0d y=%0d, required none", bus.y_id, bus.y);
        end else begin
          m_exp = exp_q.pop_front();
          if ({bus.y_id, bus.y} !== m_exp) begin
            errors++;
            $display("FAIL sb_result: id=%0d y=%0d, required id=%0d y=%0d",
                     bus.y_id, bus.y, m_exp[ID_W+W:W+1], m_exp[W:0]);
          end
        end
      end
    end
  end

  task automatic do_reset();
    @(posedge clk); #1;
    rst = 1'b1;
    bus.req = '0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  // One isolated transaction through requester k with exact latency checks
  task automatic run_one(input int k, input logic [W-1:0] a, input logic [W-1:0] b,
                         input int exp_cnt, input string tag);
    int n;
    logic [W:0] s;
    logic [NUM_REQ-1:0] oh;
    s  = {1'b0, a} + {1'b0, b};
    oh = '0;
    oh[k] = 1'b1;
    @(posedge clk); #1;
    a_arr[k] = a;
    b_arr[k] = b;
    bus.y_ready = 1'b1;
    bus.req = oh;
    n = 0;
    do begin @(negedge clk); n++; end while (bus.gnt === '0 && n < 10);
    checks++;
    if (bus.gnt !== oh || n != 1) begin
      errors++;
      $display("FAIL %s_gnt: gnt=%b after %0d cycles, required %b after 1", tag, bus.gnt, n, oh);
    end
    @(posedge clk); #1 bus.req = '0;
    n = 0;
    do begin @(negedge clk); n++; end while (!bus.y_valid && n < 10);
    checks++;
    if ({bus.y_valid, bus.y_id, bus.y} !== {1'b1, ID_W'(k), s} || n != 2) begin
      errors++;
      $display("FAIL %s_result: valid=%b id=%0d y=%h lat=%0d, required valid=1 id=%0d y=%h lat=2",
               tag, bus.y_valid, bus.y_id, bus.y, n, k, s);
    end
    @(negedge clk);
    checks++;
    if (bus.op_count !== CNT_W'(exp_cnt) || bus.y_valid !== 1'b0 || bus.busy !== 1'b0) begin
      errors++;
      $display("FAIL %s_count: op_count=%0d valid=%b busy=%b, required %0d 0 0",
               tag, bus.op_count, bus.y_valid, bus.busy, exp_cnt);
    end
  endtask

  task automatic test_reset();
    do_reset();
    @(negedge clk);
    checks++;
    if ({bus.gnt, bus.y, bus.y_id, bus.y_valid, bus.busy, bus.op_count} !== '0) begin
      errors++;
      $display("FAIL reset: gnt=%b y=%h id=%0d valid=%b busy=%b cnt=%0d, required all zero",
               bus.gnt, bus.y, bus.y_id, bus.y_valid, bus.busy, bus.op_count);
    end
  endtask

  task automatic test_single();
    run_one(0, 8'h0F, 8'h01, 1, "single");
  endtask

  task automatic test_overflow();
    run_one(2, 8'hFF, 8'hFF, 2, "ovf_max");
    run_one(2, 8'h00, 8'h00, 3, "ovf_zero");
  endtask

  task automatic test_round_robin();
    int n;
    logic [NUM_REQ-1:0] oh;
    do_reset();
    @(posedge clk); #1;
    for (int i = 0; i < NUM_REQ; i++) begin
      a_arr[i] = W'(i);
      b_arr[i] = W'(i);
    end
    bus.y_ready = 1'b1;
    bus.req = '1;
    for (int j = 0; j < 5; j++) begin
      oh = '0;
      oh[j % NUM_REQ] = 1'b1;
      n = 0;
      do begin @(negedge clk); n++; end while (bus.gnt === '0 && n < 10);
      checks++;
      if (bus.gnt !== oh || n != ((j == 0) ? 1 : 3)) begin
        errors++;
        $display("FAIL rr_gnt%0d: gnt=%b spacing=%0d, required %b spacing=%0d",
                 j, bus.gnt, n, oh, (j == 0) ? 1 : 3);
      end
    end
    @(posedge clk); #1 bus.req = '0;
    n = 0;
    do begin @(negedge clk); n++; end while (!bus.y_valid && n < 10);
    @(negedge clk);
    checks++;
    if (bus.op_count !== CNT_W'(5) || bus.busy !== 1'b0) begin
      errors++;
      $display("FAIL rr_count: op_count=%0d busy=%b, required 5 0", bus.op_count, bus.busy);
    end
  endtask

  task automatic test_backpressure();
    int n;
    @(posedge clk); #1;
    a_arr[1] = 8'd3;
    b_arr[1] = 8'd4;
    bus.y_ready = 1'b0;
    bus.req = 4'b0010;
    n = 0;
    do begin @(negedge clk); n++; end while (bus.gnt === '0 && n < 10);
    checks++;
    if (bus.gnt !== 4'b0010) begin
      errors++;
      $display("FAIL bp_gnt: gnt=%b, required 0010", bus.gnt);
    end
    n = 0;
    do begin @(negedge clk); n++; end while (!bus.y_valid && n < 10);
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      checks++;
      if ({bus.y, bus.y_id, bus.y_valid, bus.gnt, bus.busy} !== {9'd7, 2'd1, 1'b1, 4'b0000, 1'b1}) begin
        errors++;
        $display("FAIL bp_hold%0d: y=%0d id=%0d valid=%b gnt=%b busy=%b, required 7 1 1 0000 1",
                 c, bus.y, bus.y_id, bus.y_valid, bus.gnt, bus.busy);
      end
    end
    @(posedge clk); #1 bus.y_ready = 1'b1;
    @(negedge clk);
    checks++;
    if (bus.y_valid !== 1'b1 || bus.gnt !== 4'b0000) begin
      errors++;
      $display("FAIL bp_hs: valid=%b gnt=%b, required 1 0000", bus.y_valid, bus.gnt);
    end
    @(negedge clk);
    checks++;
    if (bus.gnt !== 4'b0010 || bus.y_valid !== 1'b0) begin
      errors++;
      $display("FAIL bp_regrant: gnt=%b valid=%b, required 0010 0", bus.gnt, bus.y_valid);
    end
    @(posedge clk); #1 bus.req = '0;
    n = 0;
    do begin @(negedge clk); n++; end while (!bus.y_valid && n < 10);
    @(negedge clk);
    checks++;
    if (bus.op_count !== CNT_W'(7)) begin
      errors++;
      $display("FAIL bp_count: op_count=%0d, required 7", bus.op_count);
    end
  endtask

  task automatic test_reset_mid();
    int n;
    // Reset while in CALC
    @(posedge clk); #1;
    a_arr[3] = 8'd9;
    b_arr[3] = 8'd9;
    bus.y_ready = 1'b1;
    bus.req = 4'b1000;
    n = 0;
    do begin @(negedge clk); n++; end while (bus.gnt === '0 && n < 10);
    checks++;
    if (bus.gnt !== 4'b1000) begin
      errors++;
      $display("FAIL rmid_gnt3: gnt=%b, required 1000", bus.gnt);
    end
    @(posedge clk); #1;
    bus.req = '0;
    rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    checks++;
    if ({bus.y_valid, bus.busy, bus.op_count, bus.gnt, bus.y} !== '0) begin
      errors++;
      $display("FAIL rmid_calc: valid=%b busy=%b cnt=%0d gnt=%b y=%0d, required all zero",
               bus.y_valid, bus.busy, bus.op_count, bus.gnt, bus.y);
    end
    // Reset while in OUT, after moving the pointer to 2
    @(posedge clk); #1;
    a_arr[1] = 8'd5;
    b_arr[1] = 8'd6;
    bus.y_ready = 1'b0;
    bus.req = 4'b0010;
    n = 0;
    do begin @(negedge clk); n++; end while (bus.gnt === '0 && n < 10);
    @(posedge clk); #1 bus.req = '0;
    n = 0;
    do begin @(negedge clk); n++; end while (!bus.y_valid && n < 10);
    checks++;
    if (bus.y_valid !== 1'b1) begin
      errors++;
      $display("FAIL rmid_out_valid: valid=%b, required 1", bus.y_valid);
    end
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    checks++;
    if ({bus.y_valid, bus.busy, bus.op_count, bus.y, bus.y_id} !== '0) begin
      errors++;
      $display("FAIL rmid_out: valid=%b busy=%b cnt=%0d y=%0d id=%0d, required all zero",
               bus.y_valid, bus.busy, bus.op_count, bus.y, bus.y_id);
    end
    // Pointer back at 0: requester 1 wins over 3
    @(posedge clk); #1;
    bus.y_ready = 1'b1;
    bus.req = 4'b1010;
    @(negedge clk);
    checks++;
    if (bus.gnt !== 4'b0010) begin
      errors++;
      $display("FAIL rmid_ptr: gnt=%b, required 0010", bus.gnt);
    end
    @(posedge clk); #1 bus.req = '0;
    n = 0;
    do begin @(negedge clk); n++; end while (!bus.y_valid && n < 10);
    @(negedge clk);
    checks++;
    if (bus.op_count !== CNT_W'(1)) begin
      errors++;
      $display("FAIL rmid_count: op_count=%0d, required 1", bus.op_count);
    end
  endtask

  task automatic test_sweep();
    int e0;
    do_reset();
    e0 = errors;
    for (int i = 0; i < 25; i++) run_one(3, W'(i), W'(i), i + 1, "sweep");
    if (errors == e0) $display("TEST PASSED");
    else $display("FAIL sweep: TEST FAILED with %0d mismatches, required 0", errors - e0);
  endtask

  initial begin
    rst = 1'b1;
    bus.req = '0;
    bus.y_ready = 1'b0;
    for (int k = 0; k < NUM_REQ; k++) begin
      a_arr[k] = '0;
      b_arr[k] = '0;
    end
    test_reset();
    test_single();
    test_overflow();
    test_round_robin();
    test_backpressure();
    test_reset_mid();
    test_sweep();
    repeat (3) @(negedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL sb_drain: %0d results outstanding, required 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

endmodule
